bp_me_lce_req_arbiter: RTL
==========================

# bp_me_lce_req_arbiter

Round-robin arbiter that shares one CCE's LCE-request input among `num_req_p` LCE requesters, for multi-LCE tiles and coherent-accelerator columns. Messages are BedRock header-plus-data bursts, and the grant is held until the burst's last beat. It sits between the LCE request links and the CCE request port. With the response path combinational, the only sequential state is:

- the round-robin pointer;
- the burst lock;
- an optional nonsynth watchdog.

## Interface

Parameters:
- `num_req_p`, 2: number of requesters; legal range 2..16.
- `header_width_p`, 128: width of the BedRock LCE request header.
- `data_width_p`, 64: width of one data beat.
- `watchdog_cycles_p`, 1024: maximum locked cycles without a beat transfer (watchdog build only).
- `lg_num_req_lp`, localparam: `BSG_SAFE_CLOG2(num_req_p)`.

Ports:
- `clk_i`, in, 1: clock. Single clock domain.
- `reset_i`, in, 1: synchronous, active-high reset.
- `req_header_i`, in, `num_req_p*header_width_p`: per-requester header.
- `req_data_i`, in, `num_req_p*data_width_p`: per-requester data beat.
- `req_v_i`, in, `num_req_p`: per-requester beat valid.
- `req_last_i`, in, `num_req_p`: marks the final beat of a burst.
- `req_ready_and_o`, out, `num_req_p`: per-requester ready (ready-and handshake).
- `out_header_o`, out, `header_width_p`: header of the granted requester.
- `out_data_o`, out, `data_width_p`: data beat of the granted requester.
- `out_last_o`, out, 1: last flag of the granted requester.
- `out_v_o`, out, 1: output valid.
- `out_ready_and_i`, in, 1: downstream ready.
- `grant_id_o`, out, `lg_num_req_lp`: index of the granted requester. Valid when `out_v_o` is 1.

## Operation

State:
- `rr_ptr_r`: index of the last granted requester.
- `lock_r`: burst-in-progress flag.
- `lock_id_r`: locked requester index.
- FSM states: `e_idle`, `e_locked`.

`e_idle` behaviour:
- Grant goes to the first requester with `req_v_i` set, scanning from `rr_ptr_r+1` modulo `num_req_p` upward.
- If no requester is valid, there is no grant.

`e_locked` behaviour:
- The grant is forced to `lock_id_r`.
- All other requesters see ready 0, even when their valid is 1.

Output logic:
- `out_*_o` = granted requester's fields.
- `out_v_o` = granted requester's `req_v_i`.
- `req_ready_and_o[i]` = (i == grant) & `out_ready_and_i`.
- `out_v_o` never depends on `out_ready_and_i`.

Transfer rule: a beat transfers when `out_v_o & out_ready_and_i`.

State transitions:
- `e_idle`, transfer with `out_last_o` = 1: stay in `e_idle`; `rr_ptr_r` <= grant.
- `e_idle`, transfer with `out_last_o` = 0: go to `e_locked`; `lock_id_r` <= grant.
- `e_locked`, transfer with last = 1: go to `e_idle`; `rr_ptr_r` <= `lock_id_r`.
- `e_locked`, transfer with last = 0, or no transfer: stay in `e_locked`.
- Bubbles (locked requester drops valid) keep the lock. `out_v_o` is 0 during the bubble.

## Timing

- Zero-cycle latency: the output is combinational from the inputs plus registered state.
- The grant choice and the pointer/lock update take effect on the next cycle.
- Reset values: `rr_ptr_r` = `num_req_p-1` (so requester 0 wins first); state = `e_idle`; `lock_id_r` = 0.
- During reset, `out_v_o` and all `req_ready_and_o` are forced to 0, and `grant_id_o` = 0.
- Reset asserted mid-burst aborts the lock. The next cycle is `e_idle` with the reset pointer, and the partial burst is not completed.
- A requester arriving simultaneously with the current holder's last beat competes in the next cycle, using the updated pointer.
- A single-beat burst (last = 1 on the first beat) never enters `e_locked`.
- Pointer wrap-around: from index `num_req_p-1` the scan continues at 0.
- The grant may change between cycles in `e_idle` while `out_ready_and_i` = 0. This is legal, because no beat has been accepted.

## Configuration

`BP_ME_LCE_REQ_ARB_WATCHDOG_EN`:
- Defined: a nonsynth counter increments every cycle in `e_locked` that has no transfer, and clears on any transfer or on reset. Reaching `watchdog_cycles_p` triggers `$fatal` with `lock_id_r`. Elaboration also `$fatal`s if `num_req_p` is outside 2..16.
- Undefined: no counter and no checks; RTL behaviour is otherwise identical.

## Test plan

- All 3 requesters (`num_req_p`=3) hold single-beat valid continuously, `out_ready_and_i`=1 → `grant_id_o` sequence 0,1,2,0,1,2; one transfer per cycle.
- Req0 sends a 4-beat burst while req1 is valid → `grant_id_o`=0 for 4 transfers, `req_ready_and_o[1]`=0 throughout, then `grant_id_o`=1 on the next cycle.
- Req0 burst with valid dropped for 3 cycles after beat 2 → `out_v_o`=0 for those 3 cycles, req1 still blocked, lock kept until the last beat.
- `out_ready_and_i`=0 for 5 cycles with req2 valid in `e_locked` → no state change; header/data stable on the output; no ready to other requesters.
- `reset_i` pulsed after beat 1 of a req1 burst → the next cycle is idle, and with req0 and req1 valid, `grant_id_o`=0.
- Watchdog build, `watchdog_cycles_p`=16, locked requester stalls 16 cycles → `$fatal` fires. A stall of 15 cycles followed by a transfer → no fatal.

Source files
------------

// File: rtl/bp_me_lce_req_arbiter.sv
// rtl/bp_me_lce_req_arbiter.sv - round-robin LCE request arbiter with burst lock (optional BP_ME_LCE_REQ_ARB_WATCHDOG_EN)
module bp_me_lce_req_arbiter #(
    parameter int num_req_p         = 2,
    parameter int header_width_p    = 128,
    parameter int data_width_p      = 64,
    parameter int watchdog_cycles_p = 1024,
    localparam int lg_num_req_lp    = (num_req_p <= 1) ? 1 : $clog2(num_req_p)
) (
    input  logic                                clk_i,
    input  logic                                reset_i,
    input  logic [num_req_p*header_width_p-1:0] req_header_i,
    input  logic [num_req_p*data_width_p-1:0]   req_data_i,
    input  logic [num_req_p-1:0]                req_v_i,
    input  logic [num_req_p-1:0]                req_last_i,
    output logic [num_req_p-1:0]                req_ready_and_o,
    output logic [header_width_p-1:0]           out_header_o,
    output logic [data_width_p-1:0]             out_data_o,
    output logic                                out_last_o,
    output logic                                out_v_o,
    input  logic                                out_ready_and_i,
    output logic [lg_num_req_lp-1:0]            grant_id_o
);

    typedef enum logic {
        e_idle   = 1'b0,
        e_locked = 1'b1
    } state_e;

    state_e                   state_r, state_n;
    logic [lg_num_req_lp-1:0] rr_ptr_r, rr_ptr_n;
    logic [lg_num_req_lp-1:0] lock_id_r, lock_id_n;

    logic [lg_num_req_lp-1:0] grant_id;
    logic                     grant_any;
    logic                     sel_v;
    logic                     xfer;
    int                       scan_idx;

    // Grant selection: forced to the lock holder mid-burst, otherwise the first
    // valid requester after the last winner. Scanning from the far end and
    // overwriting leaves the nearest candidate as the winner.
    always_comb begin
        grant_id  = '0;
        grant_any = 1'b0;
        scan_idx  = 0;
        if (state_r == e_locked) begin
            grant_id  = lock_id_r;
            grant_any = 1'b1;
        end else begin
            for (int k = num_req_p; k >= 1; k--) begin
                scan_idx = (int'(rr_ptr_r) + k) % num_req_p;
                if (req_v_i[scan_idx]) begin
                    grant_id  = lg_num_req_lp'(scan_idx);
                    grant_any = 1'b1;
                end
            end
        end
    end

    // Output mux and handshake; reset blanks valid, readies and the grant index.
    always_comb begin
        out_header_o    = '0;
        out_data_o      = '0;
        out_last_o      = 1'b0;
        sel_v           = 1'b0;
        req_ready_and_o = '0;
        for (int i = 0; i < num_req_p; i++) begin
            if (grant_id == lg_num_req_lp'(i)) begin
                out_header_o       = req_header_i[i*header_width_p +: header_width_p];
                out_data_o         = req_data_i[i*data_width_p +: data_width_p];
                out_last_o         = req_last_i[i];
                sel_v              = req_v_i[i];
                req_ready_and_o[i] = grant_any & out_ready_and_i & ~reset_i;
            end
        end
        out_v_o    = grant_any & sel_v & ~reset_i;
        grant_id_o = reset_i ? '0 : grant_id;
    end

    assign xfer = out_v_o & out_ready_and_i;

    // Next-state: lock on a non-final beat, release and advance the pointer on the last beat.
    always_comb begin
        state_n   = state_r;
        rr_ptr_n  = rr_ptr_r;
        lock_id_n = lock_id_r;
        case (state_r)
            e_idle: begin
                if (xfer) begin
                    if (out_last_o) begin
                        rr_ptr_n = grant_id;
                    end else begin
                        state_n   = e_locked;
                        lock_id_n = grant_id;
                    end
                end
            end
            e_locked: begin
                if (xfer && out_last_o) begin
                    state_n  = e_idle;
                    rr_ptr_n = lock_id_r;
                end
            end
            default: state_n = e_idle;
        endcase
    end

    // State register; reset drops any partial burst and makes requester 0 win first.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r   <= e_idle;
            rr_ptr_r  <= lg_num_req_lp'(num_req_p - 1);
            lock_id_r <= '0;
        end else begin
            state_r   <= state_n;
            rr_ptr_r  <= rr_ptr_n;
            lock_id_r <= lock_id_n;
        end
    end

`ifdef BP_ME_LCE_REQ_ARB_WATCHDOG_EN
    if (num_req_p < 2 || num_req_p > 16) begin : g_bad_num_req
        $fatal(1, "bp_me_lce_req_arbiter: num_req_p=%0d outside 2..16", num_req_p);
    end

    logic [31:0] wd_cnt_r;

    // Stall watchdog: counts locked cycles without a beat, aborts when the limit is reached.
    always_ff @(posedge clk_i) begin
        if (reset_i || xfer) begin
            wd_cnt_r <= '0;
        end else if (state_r == e_locked) begin
            wd_cnt_r <= wd_cnt_r + 32'd1;
        end
        if (!reset_i && wd_cnt_r >= 32'(watchdog_cycles_p)) begin
            $fatal(1, "bp_me_lce_req_arbiter: lock on requester %0d stalled %0d cycles",
                   lock_id_r, wd_cnt_r);
        end
    end
`else
    logic [31:0] wd_limit_unused;
    assign wd_limit_unused = 32'(watchdog_cycles_p);
`endif

endmodule
